// File: rtl/uart_apb_pkg.sv
// ============================================================================
// uart_apb_pkg
// Shared definitions for the UART APB register path.
//   apb_state_e      : transfer state of the APB requester
//   UART_ADDR_*      : UART register addresses used by command sources
// ============================================================================
package uart_apb_pkg;

    // IDLE waits for a command, SETUP and ACCESS are the two APB phases,
    // RESP holds the result until the command source takes it.
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    // UART register map as seen on the processor port
    localparam logic [7:0] UART_ADDR_DATA   = 8'h00;
    localparam logic [7:0] UART_ADDR_CTRL   = 8'h04;
    localparam logic [7:0] UART_ADDR_STATUS = 8'h08;
    localparam logic [7:0] UART_ADDR_BAUD   = 8'h0C;

endpackage

// File: rtl/uart_apb_master.sv
// ============================================================================
// uart_apb_master
// APB3 requester that turns single register commands into APB transfers
// towards the UART processor port. One transfer is in flight at a time;
// slave wait states are honoured and a transfer that stalls for TIMEOUT
// ACCESS cycles is aborted with an error response.
//
// Ports
//   PCLK, PRESETn               : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         : command handshake
//   cmd_write/cmd_addr/cmd_wdata: command contents
//   rsp_valid/rsp_ready         : response handshake
//   rsp_rdata/rsp_err/rsp_timeout: response contents
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : APB requester outputs
//   PRDATA/PREADY/PSLVERR       : APB completer inputs
// ============================================================================
module uart_apb_master
    import uart_apb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    // A disabled timeout still needs a legal one-bit counter.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e        state_q;
    logic              cmd_ready_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [CNT_W-1:0]  wait_cnt_d;
    logic              timeout_hit;

    // The stalled cycle being sampled now is the TIMEOUT-th one when the
    // counter already holds TIMEOUT-1; PREADY is checked first so a
    // completion on that same cycle takes priority over the abort.
    always_comb begin
        wait_cnt_d  = wait_cnt_q + CNT_W'(1);
        timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CNT_LAST);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // cmd_ready is registered, so it comes up one cycle
                    // after reset release and after every response.
                    cmd_ready_q <= 1'b1;
                    if (cmd_ready_q && cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        pwrite_q    <= cmd_write;
                        paddr_q     <= cmd_addr;
                        pwdata_q    <= cmd_write ? cmd_wdata : '0;
                        psel_q      <= 1'b1;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q  <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
                        rsp_err_q     <= PSLVERR;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                        if (timeout_hit) begin
                            rsp_rdata_q   <= '0;
                            rsp_err_q     <= 1'b1;
                            rsp_timeout_q <= 1'b1;
                            rsp_valid_q   <= 1'b1;
                            psel_q        <= 1'b0;
                            penable_q     <= 1'b0;
                            state_q       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_uart_apb_master.sv
// ============================================================================
// tb_uart_apb_master
// Self-checking bench for uart_apb_master: a table of single transfers with
// hand-computed results, plus directed sequences for response back-pressure
// and reset in the middle of a transfer.
// ============================================================================
module tb_uart_apb_master;
    import uart_apb_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA = '0;
    logic              PREADY = 1'b0;
    logic              PSLVERR = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    // One transfer: command, slave behaviour, and the response it must give.
    // waits >= TIMEOUT means the slave never raises PREADY.
    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         waits;
        logic [7:0] prdata;
        logic       slverr;
        logic [7:0] expRdata;
        logic       expErr;
        logic       expTo;
        int         expLat;
    } vec_t;

    vec_t vecs[8];

    always #5 PCLK = ~PCLK;

    uart_apb_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one command through the DUT, plays the APB slave with the
    // requested number of wait states and checks phases, latency and result.
    // The response is taken immediately (rsp_ready high).
    task automatic applyStimulus(input vec_t v, input string tag);
        int cyc;
        int acc;
        bit got;
        logic [7:0] expWdata;
        expWdata = v.wr ? v.wdata : 8'h00;
        @(negedge PCLK);
        checkOutput({tag, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        cmd_write = ~v.wr;
        PREADY    = 1'b0;
        PSLVERR   = 1'b1;
        PRDATA    = 8'hEE;
        checkOutput({tag, " setup psel"},    32'(PSEL),      32'd1);
        checkOutput({tag, " setup penable"}, 32'(PENABLE),   32'd0);
        checkOutput({tag, " setup paddr"},   32'(PADDR),     32'(v.addr));
        checkOutput({tag, " setup pwrite"},  32'(PWRITE),    32'(v.wr));
        checkOutput({tag, " setup pwdata"},  32'(PWDATA),    32'(expWdata));
        checkOutput({tag, " setup cmd_rdy"}, 32'(cmd_ready), 32'd0);
        cyc = 1;
        acc = 0;
        got = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge PCLK);
            cyc++;
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                checkOutput({tag, " access psel"},    32'(PSEL),    32'd1);
                checkOutput({tag, " access penable"}, 32'(PENABLE), 32'd1);
                checkOutput({tag, " access paddr"},   32'(PADDR),   32'(v.addr));
                checkOutput({tag, " access pwdata"},  32'(PWDATA),  32'(expWdata));
                checkOutput({tag, " access pwrite"},  32'(PWRITE),  32'(v.wr));
                if (acc >= v.waits) begin
                    PREADY  = 1'b1;
                    PRDATA  = v.prdata;
                    PSLVERR = v.slverr;
                end else begin
                    PREADY  = 1'b0;
                    PRDATA  = 8'hEE;
                    PSLVERR = 1'b1;
                end
                acc++;
            end
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 8'h00;
        if (!got) begin
            checkOutput({tag, " rsp_valid never rose"}, 32'd0, 32'd1);
        end else begin
            checkOutput({tag, " latency"},     32'(cyc),         32'(v.expLat));
            checkOutput({tag, " rsp_rdata"},   32'(rsp_rdata),   32'(v.expRdata));
            checkOutput({tag, " rsp_err"},     32'(rsp_err),     32'(v.expErr));
            checkOutput({tag, " rsp_timeout"}, 32'(rsp_timeout), 32'(v.expTo));
            checkOutput({tag, " resp psel"},   32'(PSEL),        32'd0);
            checkOutput({tag, " resp penable"}, 32'(PENABLE),    32'd0);
            checkOutput({tag, " resp cmd_rdy"}, 32'(cmd_ready),  32'd0);
            @(negedge PCLK);
            checkOutput({tag, " after rsp_valid"}, 32'(rsp_valid), 32'd0);
            checkOutput({tag, " after cmd_rdy"},   32'(cmd_ready), 32'd1);
        end
    endtask

    // Watchdog so a stuck DUT still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // wr addr wdata waits prdata slverr | rdata err to lat
        vecs[0] = '{1'b1, UART_ADDR_CTRL,   8'hA5, 0,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3};
        vecs[1] = '{1'b0, UART_ADDR_STATUS, 8'h11, 3,  8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0, 6};
        vecs[2] = '{1'b0, UART_ADDR_BAUD,   8'h00, 1,  8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, 4};
        vecs[3] = '{1'b0, UART_ADDR_DATA,   8'h00, 99, 8'h77, 1'b0, 8'h00, 1'b1, 1'b1, 18};
        vecs[4] = '{1'b0, UART_ADDR_CTRL,   8'h00, 15, 8'h77, 1'b0, 8'h77, 1'b0, 1'b0, 18};
        vecs[5] = '{1'b1, UART_ADDR_STATUS, 8'h3C, 2,  8'hC3, 1'b1, 8'h00, 1'b1, 1'b0, 5};
        vecs[6] = '{1'b0, UART_ADDR_DATA,   8'h00, 0,  8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 3};
        vecs[7] = '{1'b1, UART_ADDR_BAUD,   8'h96, 14, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 17};

        // Reset state
        #1;
        checkOutput("reset psel",      32'(PSEL),        32'd0);
        checkOutput("reset penable",   32'(PENABLE),     32'd0);
        checkOutput("reset cmd_ready", 32'(cmd_ready),   32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid),   32'd0);
        repeat (2) @(negedge PCLK);
        checkOutput("reset paddr",     32'(PADDR),       32'd0);
        checkOutput("reset pwdata",    32'(PWDATA),      32'd0);
        checkOutput("reset pwrite",    32'(PWRITE),      32'd0);
        checkOutput("reset rsp_rdata", 32'(rsp_rdata),   32'd0);
        checkOutput("reset rsp_err",   32'(rsp_err),     32'd0);
        checkOutput("reset rsp_to",    32'(rsp_timeout), 32'd0);
        PRESETn = 1'b1;
        #1;
        checkOutput("release cmd_ready early", 32'(cmd_ready), 32'd0);
        @(negedge PCLK);
        checkOutput("release cmd_ready", 32'(cmd_ready), 32'd1);

        // Table of single transfers
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], $sformatf("v%0d", i));
        end

        // Response back-pressure with a second command already waiting
        @(negedge PCLK);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = UART_ADDR_STATUS;
        PREADY    = 1'b1;
        PRDATA    = 8'h42;
        PSLVERR   = 1'b0;
        @(negedge PCLK);
        checkOutput("stall setup psel",    32'(PSEL),    32'd1);
        checkOutput("stall setup penable", 32'(PENABLE), 32'd0);
        @(negedge PCLK);
        checkOutput("stall access penable", 32'(PENABLE), 32'd1);
        @(negedge PCLK);
        PRDATA = 8'h99;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge PCLK);
            checkOutput($sformatf("stall%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
            checkOutput($sformatf("stall%0d rsp_rdata", i), 32'(rsp_rdata), 32'h42);
            checkOutput($sformatf("stall%0d cmd_ready", i), 32'(cmd_ready), 32'd0);
            checkOutput($sformatf("stall%0d psel", i),      32'(PSEL),      32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        checkOutput("stall release rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("stall release cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("stall release psel",      32'(PSEL),      32'd0);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        checkOutput("stall second setup psel",    32'(PSEL),    32'd1);
        checkOutput("stall second setup penable", 32'(PENABLE), 32'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        checkOutput("stall second rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("stall second rsp_rdata", 32'(rsp_rdata), 32'h99);
        PREADY = 1'b0;
        PRDATA = 8'h00;
        @(negedge PCLK);

        // Reset asserted while the slave is stalling in ACCESS
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = UART_ADDR_DATA;
        cmd_wdata = 8'h5F;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        checkOutput("rst-mid access penable", 32'(PENABLE), 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        checkOutput("rst-mid psel",      32'(PSEL),      32'd0);
        checkOutput("rst-mid penable",   32'(PENABLE),   32'd0);
        checkOutput("rst-mid rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst-mid cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst-mid paddr",     32'(PADDR),     32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        applyStimulus('{1'b1, UART_ADDR_CTRL, 8'h3D, 1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4},
                      "post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_apb_master.md
# uart_apb_master

APB3 requester that turns single register commands into APB transfers towards the UART top's processor port (PSEL/PENABLE/PWRITE/PADDR/PWDATA out, PRDATA/PREADY/PSLVERR in). It is the initiator end of the UART register interface. It sits between an on-chip command source (DMA sequencer or CPU shim) and the UART APB slave. It handles one outstanding transfer, honours wait states and aborts transfers that stall past a timeout.

## Interface
- ADDR_W, 8, APB address width
- DATA_W, 8, APB data width
- TIMEOUT, 16, max consecutive ACCESS cycles with PREADY low before abort; 0 disables the timeout
- Clock and reset: one clock, PCLK; reset is asynchronous and active-low, PRESETn.
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 write, 0 read
- cmd_addr  in  ADDR_W  target register address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers
- rsp_err  out  1  PSLVERR seen or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY, PSLVERR  in  1  APB completion and error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA; PWDATA=0 for reads. Go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Clear the wait counter. Always go to ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: capture PRDATA into rsp_rdata (reads only) and PSLVERR into rsp_err. rsp_timeout=0. Go to RESP.
  - PREADY=0: increment the wait counter (width $clog2(TIMEOUT+1)). If TIMEOUT≠0 and the counter reaches TIMEOUT, abort: rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
- RESP: PSEL=PENABLE=0, rsp_valid=1 and held with stable data until rsp_ready. On handshake, go to IDLE.
- PADDR/PWRITE/PWDATA are stable from SETUP through the last ACCESS cycle. They hold their last values outside a transfer.
- cmd_ready is low in SETUP, ACCESS and RESP; commands there are stalled, not dropped.
- PSLVERR and PRDATA are ignored unless PSEL&PENABLE&PREADY.
- Reset values: all outputs 0; state IDLE. cmd_ready rises the first cycle after reset release.
- Reset mid-transfer: PSEL/PENABLE drop asynchronously; any pending response is discarded.

## Timing
- Command handshake at edge N → SETUP during cycle N+1 → ACCESS from N+2.
- Zero-wait slave: PREADY=1 in N+2 → rsp_valid during N+3. Back-to-back minimum is 4 cycles per transfer with rsp_ready tied high.
- k wait states (k<TIMEOUT): rsp_valid during N+3+k.
- Timeout: PREADY low for TIMEOUT ACCESS cycles → PSEL/PENABLE low and rsp_valid during N+2+TIMEOUT.
- PREADY rising in the same cycle the counter would hit TIMEOUT: completion wins; no timeout.
- rsp_valid, once high, stays high until rsp_ready. No combinational path from APB inputs to outputs.

## Structure
- Shared package uart_apb_pkg holds:
  - the FSM state enum (apb_state_e)
  - UART register address constants used by command sources and benches
- Single module; no sub-module is warranted. The wait counter is inline.

## Test plan
- Write 0xA5 to 0x04, PREADY tied 1 → PSEL high 2 cycles with PENABLE in cycle 2; PADDR=0x04, PWDATA=0xA5 stable; rsp_valid at N+3 with rsp_err=0.
- Read 0x08, slave returns 0x3C after 3 wait states → rsp_valid at N+6, rsp_rdata=0x3C, PADDR stable throughout ACCESS.
- Read with PSLVERR=1 on completion → rsp_err=1, rsp_timeout=0, rsp_rdata=PRDATA.
- PREADY held 0 with TIMEOUT=16 → abort after 16 ACCESS cycles, rsp_err=rsp_timeout=1, rsp_rdata=0; second case with PREADY=1 on cycle 16 → normal completion.
- rsp_ready low 5 cycles while cmd_valid held → rsp_valid/data stable, cmd_ready=0, no new SETUP until the response handshake.
- PRESETn asserted during ACCESS → PSEL/PENABLE/rsp_valid 0 immediately; after release cmd_ready=1 and a fresh write completes normally.
